sumador_acumulador: RTL and testbench
=====================================

SUMADOR_ACUMULADOR -- requirements
Module: sumador_acumulador

Interface
REQ-001 Parameter Q1, default 26, width of input x1.
REQ-002 Parameter Q2, default 26, width of input x2.
REQ-003 Parameter N_AVG, default 16, samples per accumulation block; legal range 2..65536.
REQ-004 Parameter QO, default max(Q1,Q2)+1+clog2(N_AVG), output width; values smaller than this default are illegal.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 x1  input  Q1  signed two's-complement operand.
REQ-008 x2  input  Q2  signed two's-complement operand.
REQ-009 data_valid  input  1  x1/x2 are valid this cycle.
REQ-010 mode  input  1  0 = pairwise sum, 1 = block accumulate.
REQ-011 clear  input  1  synchronous flush of accumulator, counter and pipeline.
REQ-012 y  output  QO  signed result, held between updates.
REQ-013 data_valid_out  output  1  one-cycle pulse; y updated this cycle.
REQ-014 done  output  1  one-cycle pulse; end of accumulation block (mode 1 only).

Function
REQ-015 Stage 1 SHALL register x1, x2, data_valid and mode on each edge.
REQ-016 Stage 2 SHALL register psum = sext(x1_s1) + sext(x2_s1) at max(Q1,Q2)+1 bits, plus its valid and mode.
REQ-017 Mode 0: on a stage-2 valid, y <= sext(psum) and data_valid_out = 1 on the third edge after data_valid was sampled; done stays 0.
REQ-018 Mode 1: on each stage-2 valid, acc <= acc + sext(psum) and cnt increments.
REQ-019 Mode 1: the N_AVG-th valid sample SHALL produce y <= acc + sext(psum), assert data_valid_out and done together for one cycle, and reset acc and cnt to 0 on that edge.
REQ-020 cnt SHALL range 0..N_AVG-1 and wrap to 0 only via REQ-019.
REQ-021 Gaps in data_valid SHALL NOT affect results; acc and cnt change only on valid samples.
REQ-022 Back-to-back valid samples SHALL be accepted at one per cycle, including across block boundaries.
REQ-023 Arithmetic SHALL NOT wrap or saturate; QO guarantees exact results.
REQ-024 clear = 1 SHALL zero acc, cnt and all pipeline valid bits on that edge; y is held and no pulse is issued.
REQ-025 If clear and data_valid are both 1 in the same cycle, clear SHALL win and the sample SHALL be dropped.
REQ-026 A change of the mode input relative to the previous cycle SHALL act as clear (REQ-024) on that edge.
REQ-027 Samples that are in flight when mode changes SHALL be dropped, and the partial block SHALL be discarded.
REQ-028 data_valid_out and done SHALL never be asserted for more than one consecutive cycle per result.

Reset
REQ-029 reset_n low SHALL immediately clear, without waiting for clk: all stage registers, acc, cnt, y, data_valid_out and done to 0.
REQ-030 The captured mode register SHALL reset to 0.
REQ-031 After reset_n deasserts, the first valid sample in mode 1 SHALL be sample 1 of a new block.
REQ-032 Reset mid-block SHALL discard the partial accumulation.

Verification
REQ-033 Mode 0: x1=5, x2=-3, data_valid one cycle -> y=2, data_valid_out pulse exactly 3 edges later, done=0.
REQ-034 Mode 0 extremes (Q1=Q2=26):
- x1 = x2 = 2^25-1 -> y = 2^26-2.
- x1 = x2 = -2^25 -> y = -2^26.
REQ-035 Mode 1 with N_AVG=16: 16 back-to-back samples of x1=1000, x2=24 -> y=16384, with done and data_valid_out pulsed once 3 edges after sample 16; the next 16 samples of x1=-1, x2=0 -> y=-16.
REQ-036 Mode 1 with data_valid every 3rd cycle and the same data as REQ-035 -> identical y=16384 and a single done.
REQ-037 Mode 1: 7 samples, then clear asserted together with a valid sample, then 16 samples of 1,0 -> y=16; a mode toggle mid-block gives the same discard behaviour.
REQ-038 Mode 1: reset_n pulsed low after 9 samples -> outputs 0 immediately; the following 16 samples of 2,2 -> y=64.

Source files
------------

// File: rtl/sumador_acumulador_if.sv
// Operand/result bundle for sumador_acumulador: the master drives operands and
// control, the slave returns the registered result and its strobes.
interface sumador_acumulador_if #(
  parameter int Q1 = 26,
  parameter int Q2 = 26,
  parameter int QO = 31
);
  logic signed [Q1-1:0] x1;
  logic signed [Q2-1:0] x2;
  logic                 data_valid;
  logic                 mode;
  logic                 clear;
  logic signed [QO-1:0] y;
  logic                 data_valid_out;
  logic                 done;

  modport master (
    output x1, x2, data_valid, mode, clear,
    input  y, data_valid_out, done
  );

  modport slave (
    input  x1, x2, data_valid, mode, clear,
    output y, data_valid_out, done
  );
endinterface

// File: rtl/sumador_acumulador.sv
// Three-stage pairwise adder / block accumulator: capture, add, then either
// forward the pair sum (mode 0) or accumulate N_AVG sums into one result (mode 1).
module sumador_acumulador #(
  parameter int Q1    = 26,
  parameter int Q2    = 26,
  parameter int N_AVG = 16,
  parameter int QO    = ((Q1 > Q2) ? Q1 : Q2) + 1 + $clog2(N_AVG)
) (
  input  logic               clk,
  input  logic               reset_n,
  sumador_acumulador_if.slave bus
);
  localparam int QP     = ((Q1 > Q2) ? Q1 : Q2) + 1;
  localparam int CW     = $clog2(N_AVG);
  localparam int STAGES = 2;

  typedef struct packed {
    logic signed [Q1-1:0] x1;
    logic signed [Q2-1:0] x2;
    logic                 mode;
  } s1_t;

  typedef struct packed {
    logic signed [QP-1:0] psum;
    logic                 mode;
  } s2_t;

  s1_t                  s1;
  s2_t                  s2;
  logic [STAGES:1]      vld_pipe;
  logic signed [QO-1:0] acc;
  logic [CW-1:0]        cnt;
  logic signed [QO-1:0] y_q;
  logic                 dvo_q;
  logic                 done_q;

  logic                 flush;
  logic signed [QP-1:0] psum_nxt;
  logic signed [QO-1:0] psum_ext;
  logic signed [QO-1:0] acc_sum;
  logic                 cnt_last;

  // A mode change is judged against the mode captured on the previous edge,
  // so it flushes exactly once and the in-flight samples of the old mode die.
  assign flush    = bus.clear | (bus.mode != s1.mode);
  assign psum_nxt = QP'(s1.x1) + QP'(s1.x2);
  assign psum_ext = QO'(s2.psum);
  assign acc_sum  = acc + psum_ext;
  assign cnt_last = (cnt == CW'(N_AVG - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1          <= '0;
      vld_pipe[1] <= 1'b0;
    end else begin
      s1.x1       <= bus.x1;
      s1.x2       <= bus.x2;
      s1.mode     <= bus.mode;
      vld_pipe[1] <= bus.data_valid & ~flush;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2          <= '0;
      vld_pipe[2] <= 1'b0;
    end else begin
      s2.psum     <= psum_nxt;
      s2.mode     <= s1.mode;
      vld_pipe[2] <= vld_pipe[1] & ~flush;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc    <= '0;
      cnt    <= '0;
      y_q    <= '0;
      dvo_q  <= 1'b0;
      done_q <= 1'b0;
    end else if (flush) begin
      // y is deliberately held across a flush; only the partial block is lost.
      acc    <= '0;
      cnt    <= '0;
      dvo_q  <= 1'b0;
      done_q <= 1'b0;
    end else if (vld_pipe[2]) begin
      if (!s2.mode) begin
        y_q    <= psum_ext;
        dvo_q  <= 1'b1;
        done_q <= 1'b0;
      end else if (cnt_last) begin
        y_q    <= acc_sum;
        acc    <= '0;
        cnt    <= '0;
        dvo_q  <= 1'b1;
        done_q <= 1'b1;
      end else begin
        acc    <= acc_sum;
        cnt    <= cnt + CW'(1);
        dvo_q  <= 1'b0;
        done_q <= 1'b0;
      end
    end else begin
      dvo_q  <= 1'b0;
      done_q <= 1'b0;
    end
  end

  assign bus.y              = y_q;
  assign bus.data_valid_out = dvo_q;
  assign bus.done           = done_q;
endmodule

// File: tb/tb_sumador_acumulador.sv
// Directed bench for sumador_acumulador with default parameters
// (Q1=Q2=26, N_AVG=16, QO=31); expected values are hand-computed.
module tb_sumador_acumulador;
  logic clk;
  logic reset_n;

  sumador_acumulador_if #(.Q1(26), .Q2(26), .QO(31)) bus ();

  sumador_acumulador #(.Q1(26), .Q2(26), .N_AVG(16), .QO(31)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  logic signed [30:0] ys[$];
  int dcs[$];
  int cyc_n = 0;
  int dvo_cyc = -1;
  int n_done = 0;
  int n_done_solo = 0;
  int n_dbl = 0;
  logic prev_dvo = 1'b0;

  task automatic clr_obs();
    ys.delete();
    dcs.delete();
    dvo_cyc     = -1;
    n_done      = 0;
    n_done_solo = 0;
    n_dbl       = 0;
  endtask

  // Drive one cycle of inputs, then observe outputs 1 time unit after the edge.
  task automatic step(input logic v, input logic signed [25:0] a, input logic signed [25:0] b);
    bus.data_valid = v;
    bus.x1 = a;
    bus.x2 = b;
    @(posedge clk);
    #1;
    cyc_n++;
    if (bus.data_valid_out) begin
      ys.push_back(bus.y);
      dvo_cyc = cyc_n;
    end
    if (bus.done) begin
      n_done++;
      dcs.push_back(cyc_n);
      if (!bus.data_valid_out) n_done_solo++;
    end
    if (bus.data_valid_out && prev_dvo) n_dbl++;
    prev_dvo = bus.data_valid_out;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 26'sd0, 26'sd0);
  endtask

  task automatic test_reset();
    #2;
    checks++; if (bus.y !== 31'sd0) $display("FAIL reset_y: got %0d want 0", bus.y); else passed++;
    checks++; if (bus.data_valid_out !== 1'b0) $display("FAIL reset_dvo: got %b want 0", bus.data_valid_out); else passed++;
    checks++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done); else passed++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_mode0_basic();
    int k;
    clr_obs();
    step(1'b1, 26'sd5, -26'sd3);
    k = cyc_n;
    idle(4);
    checks++; if (ys.size() != 1 || ys[0] !== 31'sd2) $display("FAIL m0_sum: got n=%0d y=%0d want n=1 y=2", ys.size(), bus.y); else passed++;
    // pulse visible after the third edge counting the sampling edge
    checks++; if (dvo_cyc !== k + 2) $display("FAIL m0_latency: got cyc %0d want %0d", dvo_cyc, k + 2); else passed++;
    checks++; if (n_done !== 0) $display("FAIL m0_done: got %0d want 0", n_done); else passed++;
  endtask

  task automatic test_mode0_extremes();
    clr_obs();
    step(1'b1, 26'sh1FFFFFF, 26'sh1FFFFFF);
    step(1'b1, 26'sh2000000, 26'sh2000000);
    idle(4);
    checks++; if (ys.size() != 2) $display("FAIL m0_ext_count: got %0d want 2", ys.size()); else passed++;
    checks++; if (ys.size() < 1 || ys[0] !== 31'sd67108862) $display("FAIL m0_ext_max: got %0d want 67108862", (ys.size() > 0) ? ys[0] : 31'sd0); else passed++;
    checks++; if (ys.size() < 2 || ys[1] !== -31'sd67108864) $display("FAIL m0_ext_min: got %0d want -67108864", (ys.size() > 1) ? ys[1] : 31'sd0); else passed++;
  endtask

  task automatic test_mode1_back_to_back();
    int k16;
    bus.mode = 1'b1;
    idle(1);
    clr_obs();
    for (int i = 0; i < 16; i++) step(1'b1, 26'sd1000, 26'sd24);
    k16 = cyc_n;
    for (int i = 0; i < 16; i++) step(1'b1, -26'sd1, 26'sd0);
    idle(4);
    checks++; if (ys.size() != 2 || ys[0] !== 31'sd16384) $display("FAIL m1_block1: got n=%0d y0=%0d want n=2 y0=16384", ys.size(), (ys.size() > 0) ? ys[0] : 31'sd0); else passed++;
    checks++; if (ys.size() < 2 || ys[1] !== -31'sd16) $display("FAIL m1_block2: got %0d want -16", (ys.size() > 1) ? ys[1] : 31'sd0); else passed++;
    checks++; if (n_done !== 2) $display("FAIL m1_done_count: got %0d want 2", n_done); else passed++;
    checks++; if (dcs.size() < 1 || dcs[0] !== k16 + 2) $display("FAIL m1_done_latency: got %0d want %0d", (dcs.size() > 0) ? dcs[0] : -1, k16 + 2); else passed++;
    checks++; if (n_done_solo !== 0 || n_dbl !== 0) $display("FAIL m1_pulse_shape: got solo=%0d dbl=%0d want 0 0", n_done_solo, n_dbl); else passed++;
  endtask

  task automatic test_gaps();
    clr_obs();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 26'sd1000, 26'sd24);
      idle(2);
    end
    idle(4);
    checks++; if (ys.size() != 1 || ys[0] !== 31'sd16384) $display("FAIL gap_y: got n=%0d y=%0d want n=1 y=16384", ys.size(), bus.y); else passed++;
    checks++; if (n_done !== 1) $display("FAIL gap_done: got %0d want 1", n_done); else passed++;
  endtask

  task automatic test_clear();
    clr_obs();
    for (int i = 0; i < 7; i++) step(1'b1, 26'sd100, 26'sd0);
    bus.clear = 1'b1;
    step(1'b1, 26'sd100, 26'sd0);
    bus.clear = 1'b0;
    for (int i = 0; i < 16; i++) step(1'b1, 26'sd1, 26'sd0);
    idle(4);
    checks++; if (ys.size() != 1 || ys[0] !== 31'sd16) $display("FAIL clear_y: got n=%0d y=%0d want n=1 y=16", ys.size(), bus.y); else passed++;
    checks++; if (n_done !== 1) $display("FAIL clear_done: got %0d want 1", n_done); else passed++;
  endtask

  task automatic test_mode_toggle();
    clr_obs();
    for (int i = 0; i < 7; i++) step(1'b1, 26'sd100, 26'sd0);
    bus.mode = 1'b0;
    idle(1);
    bus.mode = 1'b1;
    idle(1);
    for (int i = 0; i < 16; i++) step(1'b1, 26'sd1, 26'sd0);
    idle(4);
    checks++; if (ys.size() != 1 || ys[0] !== 31'sd16) $display("FAIL toggle_y: got n=%0d y=%0d want n=1 y=16", ys.size(), bus.y); else passed++;
    checks++; if (n_done !== 1) $display("FAIL toggle_done: got %0d want 1", n_done); else passed++;
  endtask

  task automatic test_reset_mid_block();
    clr_obs();
    for (int i = 0; i < 9; i++) step(1'b1, 26'sd2, 26'sd2);
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (bus.y !== 31'sd0) $display("FAIL rst_mid_y: got %0d want 0", bus.y); else passed++;
    checks++; if (bus.data_valid_out !== 1'b0 || bus.done !== 1'b0) $display("FAIL rst_mid_strobes: got %b%b want 00", bus.data_valid_out, bus.done); else passed++;
    #1;
    reset_n = 1'b1;
    prev_dvo = 1'b0;
    idle(1);
    clr_obs();
    for (int i = 0; i < 16; i++) step(1'b1, 26'sd2, 26'sd2);
    idle(4);
    checks++; if (ys.size() != 1 || ys[0] !== 31'sd64) $display("FAIL rst_mid_block: got n=%0d y=%0d want n=1 y=64", ys.size(), bus.y); else passed++;
    checks++; if (n_done !== 1) $display("FAIL rst_mid_done: got %0d want 1", n_done); else passed++;
  endtask

  initial begin
    reset_n        = 1'b1;
    bus.x1         = '0;
    bus.x2         = '0;
    bus.data_valid = 1'b0;
    bus.mode       = 1'b0;
    bus.clear      = 1'b0;
    #1;
    reset_n = 1'b0;
    test_reset();
    test_mode0_basic();
    test_mode0_extremes();
    test_mode1_back_to_back();
    test_gaps();
    test_clear();
    test_mode_toggle();
    test_reset_mid_block();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
